// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } state_e;

  localparam logic [31:0] FETCH_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory bus and decode-side valid/ready handshake of the fetch controller.
interface ifetch_if;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output mem_read, mem_addr, out_valid, out_instr, out_pc,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_read, mem_addr, out_valid, out_instr, out_pc,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: circular FIFO of {pc, instr} entries with synchronous flush.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output entry_t          head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  entry_t          mem_q [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, redirect handling, prefetch buffer.
// Optional IFETCH_HALT_ON_ZERO_EN: a fetched all-zero word halts fetching instead of being queued.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned PC_LIMIT   = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  ifetch_if.master        bus,
  output logic            busy,
  output logic            halted
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            busy_q;
  logic [31:0]     pc_inc, pc_next, redirect_tgt;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  entry_t          fifo_head;
  logic            pop_raw, fetch_en, do_fetch, do_pop, do_push, zero_word;

  assign pc_inc       = pc_q + FETCH_STEP;
  assign pc_next      = (pc_inc >= PC_LIMIT) ? RESET_PC : pc_inc;
  assign redirect_tgt = redirect_pc & ~32'h3;

  assign pop_raw  = bus.out_valid && bus.out_ready;
  assign fetch_en = (state_q == StFetch) && (!fifo_full || pop_raw);
  // A redirect discards both the same-cycle fetch and the same-cycle pop.
  assign do_fetch = fetch_en && !redirect_valid;
  assign do_pop   = pop_raw && !redirect_valid;

`ifdef IFETCH_HALT_ON_ZERO_EN
  assign zero_word = (bus.mem_rdata == 32'h0);
`else
  assign zero_word = 1'b0;
`endif

  assign do_push = do_fetch && !zero_word;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (do_fetch) begin
          if (zero_word) state_d = StHalt;
          else           pc_d    = pc_next;
        end
      end
      StHalt: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= (state_d != StIdle);
    end
  end

`ifdef IFETCH_HALT_ON_ZERO_EN
  logic halted_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= (state_d == StHalt);
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  ifetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (do_push),
    .push_data_i('{pc: pc_q, instr: bus.mem_rdata}),
    .pop_i      (do_pop),
    .flush_i    (redirect_valid),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  logic unused_count;
  assign unused_count = ^fifo_count;

  assign busy          = busy_q;
  assign bus.mem_read  = fetch_en;
  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = fifo_empty ? 32'h0 : fifo_head.instr;
  assign bus.out_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule
